instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute controller that drives the 8-bit CPU `data_path`. It owns the program counter, fetches 16-bit instructions from an external synchronous instruction memory, and splits each word into the datapath's opcode, register-select and immediate fields. It presents a non-NOP opcode for exactly one cycle per instruction, so the register file is written at most once per instruction. It sits between the instruction ROM and `data_path`, and exposes a start/busy/halted handshake to the testbench or top level.

## Interface
- `PC_W`, 8: program counter and instruction-address width.
- `START_ADDR`, 0: PC load value on start and reset.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start`  input  1  begin execution; sampled only in IDLE or HALTED.
- `imem_en`  output  1  instruction-memory read enable.
- `imem_addr`  output  PC_W  instruction-memory address.
- `imem_rdata`  input  16  instruction word, valid the cycle after `imem_en`.
- `dp_opcode`  output  4  to `data_path` Opcode; 4'h0 (NOP) outside EXEC.
- `dp_src1`  output  3  to SrcReg1 = IR[8:6].
- `dp_src2`  output  3  to SrcReg2 = IR[5:3].
- `dp_dest`  output  3  to DestReg = IR[11:9].
- `dp_imm`  output  8  to Immediate = IR[7:0].
- `busy`  output  1  high from FETCH through EXEC.
- `halted`  output  1  high in HALTED.
- `pc`  output  PC_W  current program counter.
- `retired`  output  16  count of executed instructions, saturating at 16'hFFFF.

## Operation
- Instruction format: [15:12] opcode, [11:9] dest, [8:6] src1, [5:3] src2, [7:0] imm. The fields overlap; `data_path` ignores the fields it does not use.
- Reserved opcodes handled by the sequencer, and never forwarded to the datapath:
  - 4'hF HALT.
  - 4'hD JMP: pc <= imm[PC_W-1:0].
  - 4'h0 NOP.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE: if `start`, load pc <= START_ADDR, clear `retired`, go to FETCH.
- FETCH: imem_en=1, imem_addr=pc; go to DECODE.
- DECODE: IR <= imem_rdata.
  - If imem_rdata[15:12]==4'hF, go to HALTED; pc is unchanged and `retired` is not incremented.
  - Otherwise go to EXEC.
- EXEC:
  - Drive dp_opcode=IR[15:12], except 4'hD/4'h0, which drive 4'h0.
  - pc <= (JMP ? imm : pc+1), wrapping modulo 2^PC_W.
  - retired += 1 (saturating).
  - Go to FETCH.
- HALTED: hold pc, IR and `retired`. On `start`, behave as IDLE+start (restart from START_ADDR).
- `start` asserted while busy is ignored.
- The dp_src/dest/imm outputs reflect IR continuously. Only dp_opcode is gated.

## Timing
- Reset values:
  - state=IDLE.
  - pc=START_ADDR.
  - IR=16'h0000, so dp_opcode=0 and dp_src1/dp_src2/dp_dest/dp_imm=0.
  - imem_en=0.
  - imem_addr=START_ADDR.
  - busy=0, halted=0, retired=0.
- Latency: `start` at cycle 0 gives FETCH in cycle 1, DECODE in cycle 2 and EXEC in cycle 3. The register-file write occurs on the clock edge ending cycle 3.
- Throughput: 3 cycles per instruction; the next FETCH follows in cycle 4.
- dp_opcode is non-zero for exactly one cycle per executed instruction.
- HALT: DECODE of HALT gives halted=1 and busy=0 in the following cycle. No EXEC cycle occurs.
- Reset mid-instruction: rst_n=0 at any clock forces the reset values on the next edge. dp_opcode is 0 from that edge on, so no write is issued after reset is sampled.
- PC wrap: pc=2^PC_W-1 followed by a non-jump instruction gives pc=0.

## Configuration
- `INSTR_SEQ_SINGLE_STEP_EN` defined: adds input port `step` (1 bit).
  - DECODE→EXEC transitions only in a cycle where `step`=1; otherwise the FSM holds DECODE and busy stays 1.
  - HALT detection is not gated by `step`.
- Macro undefined: no `step` port; DECODE→EXEC is unconditional.

## Test plan
- Reset then start, memory {0:16'h1250, 1:16'hF000}:
  - dp_opcode=4'h1 for exactly one cycle, in cycle 3.
  - Cycle 3 fields: dp_dest=1, dp_src1=1, dp_src2=2.
  - Then halted=1, pc=1, retired=1.
- Memory {0:16'hD005, 5:16'hF000}:
  - dp_opcode stays 0 throughout.
  - pc goes 0→5; halted with retired=1.
- PC_W=8, START_ADDR=8'hFF, mem[FF]=16'h2000, mem[0]=16'hF000: pc wraps FF→00, then halts.
- rst_n=0 asserted in the DECODE cycle of instruction 0:
  - Next cycle: state IDLE, busy=0, pc=0.
  - dp_opcode is never non-zero.
- `start` pulsed during EXEC: ignored; retired and pc follow the program unchanged. After halt, `start` restarts at START_ADDR with retired=0.
- With `INSTR_SEQ_SINGLE_STEP_EN`, step held 0 for 10 cycles:
  - FSM stays in DECODE and dp_opcode=0.
  - A one-cycle step pulse produces EXEC on the next cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit data_path: owns the PC, fetches 16-bit words, gates the opcode to one EXEC cycle.
// Optional INSTR_SEQ_SINGLE_STEP_EN adds a `step` input that gates the DECODE->EXEC transition.
module instr_sequencer #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      dp_opcode,
  output logic [2:0]      dp_src1,
  output logic [2:0]      dp_src2,
  output logic [2:0]      dp_dest,
  output logic [7:0]      dp_imm,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     ir, ir_next;
  logic [15:0]     retired_next;
  logic            step_ok;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= START_ADDR;
      ir      <= '0;
      retired <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      retired <= retired_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    retired_next = retired;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_next      = START_ADDR;
          retired_next = '0;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        // IR reloads while DECODE is held; the memory keeps its output with imem_en low.
        ir_next = imem_rdata;
        if (imem_rdata[15:12] == OP_HALT) state_next = S_HALTED;
        else if (step_ok)                 state_next = S_EXEC;
      end
      S_EXEC: begin
        pc_next      = (ir[15:12] == OP_JMP) ? PC_W'(ir[7:0]) : pc + PC_W'(1);
        retired_next = (retired == '1) ? retired : retired + 16'd1;
        state_next   = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dp_opcode = '0;
    if (state == S_EXEC && ir[15:12] != OP_NOP && ir[15:12] != OP_JMP)
      dp_opcode = ir[15:12];
  end

  assign imem_en   = (state == S_FETCH);
  assign imem_addr = pc;
  assign dp_dest   = ir[11:9];
  assign dp_src1   = ir[8:6];
  assign dp_src2   = ir[5:3];
  assign dp_imm    = ir[7:0];
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level program walk predicts every cycle's outputs from the 3-cycle schedule.
// Build with +define+INSTR_SEQ_SINGLE_STEP_EN to also exercise the step gate.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [3:0]  dp_opcode;
  logic [2:0]  dp_src1, dp_src2, dp_dest;
  logic [7:0]  dp_imm;
  logic        busy, halted;
  logic [7:0]  pc;
  logic [15:0] retired;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .START_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dp_opcode(dp_opcode), .dp_src1(dp_src1), .dp_src2(dp_src2), .dp_dest(dp_dest),
    .dp_imm(dp_imm), .busy(busy), .halted(halted), .pc(pc), .retired(retired)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int n_cmp = 0, n_bad = 0;
  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, set just after each edge and checked on the falling edge.
  bit          chk_on = 1'b0;
  logic        e_en, e_busy, e_halted;
  logic [7:0]  e_pc;
  logic [15:0] e_ret, e_ir;
  logic [3:0]  e_opc;

  always @(negedge clk) if (chk_on) begin
    cmp("imem_en", imem_en, e_en);
    cmp("imem_addr", imem_addr, e_pc);
    cmp("busy", busy, e_busy);
    cmp("halted", halted, e_halted);
    cmp("pc", pc, e_pc);
    cmp("retired", retired, e_ret);
    cmp("dp_opcode", dp_opcode, e_opc);
    cmp("dp_dest", dp_dest, e_ir[11:9]);
    cmp("dp_src1", dp_src1, e_ir[8:6]);
    cmp("dp_src2", dp_src2, e_ir[5:3]);
    cmp("dp_imm", dp_imm, e_ir[7:0]);
  end

  int         opc_cnt = 0;
  logic [3:0] l_op;
  logic [2:0] l_dest, l_src1, l_src2;
  logic [7:0] prev_pc = '0;
  bit         wrap_seen = 1'b0;
  always @(negedge clk) begin
    if (dp_opcode != 4'h0) begin
      opc_cnt++;
      l_op = dp_opcode; l_dest = dp_dest; l_src1 = dp_src1; l_src2 = dp_src2;
    end
    if (prev_pc == 8'hFF && pc == 8'h00) wrap_seen = 1'b1;
    prev_pc = pc;
  end

  // Architectural state carried between runs.
  logic [7:0]  m_pc;
  logic [15:0] m_ret, m_ir;
  bit          m_halted;

  logic [7:0]  t_addr [64];
  logic [15:0] t_word [64];
  int          t_h;

  function automatic logic [3:0] fwd(input logic [15:0] w);
    return (w[15:12] == 4'hD || w[15:12] == 4'h0) ? 4'h0 : w[15:12];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    e_en = 0; e_busy = 0; e_halted = 0; e_pc = '0; e_ret = '0; e_opc = '0; e_ir = '0;
    m_pc = '0; m_ret = '0; m_ir = '0; m_halted = 0;
  endtask

  // Start a program, follow it for up to len cycles; reset at the last cycle if it has not halted.
  task automatic run_prog(input int len, input bit pulses);
    int n, last, k, ph;
    bit cut;
    logic [7:0] p;
    n = len / 3 + 2;
    p = 8'h00;
    t_h = -1;
    for (int i = 0; i < n; i++) begin
      t_addr[i] = p;
      t_word[i] = mem[p];
      if (mem[p][15:12] == 4'hF) begin t_h = i; break; end
      p = (mem[p][15:12] == 4'hD) ? mem[p][7:0] : p + 8'd1;
    end
    cut  = !(t_h >= 0 && 3 * t_h + 4 <= len);
    last = cut ? len : 3 * t_h + 4;
    tick();
    e_en = 0; e_busy = 0; e_halted = m_halted; e_pc = m_pc; e_ret = m_ret; e_opc = '0; e_ir = m_ir;
    start = 1;
    for (int t = 1; t <= last; t++) begin
      tick();
      start = 0;
      k  = (t - 1) / 3;
      ph = (t - 1) % 3;
      if (t_h >= 0 && t >= 3 * t_h + 3) begin
        e_en = 0; e_busy = 0; e_halted = 1; e_pc = t_addr[t_h];
        e_ret = 16'(t_h); e_opc = '0; e_ir = t_word[t_h];
      end else begin
        e_en = (ph == 0); e_busy = 1; e_halted = 0; e_pc = t_addr[k]; e_ret = 16'(k);
        e_opc = (ph == 2) ? fwd(t_word[k]) : 4'h0;
        e_ir  = (ph == 2) ? t_word[k] : ((k == 0) ? m_ir : t_word[k-1]);
        if (pulses && $urandom_range(0, 4) == 0) start = 1;
      end
      if (cut && t == last) rst_n = 0;
    end
    if (cut) begin
      tick();
      rst_n = 1;
      start = 0;
      set_reset_exp();
    end else begin
      m_pc = t_addr[t_h]; m_ret = 16'(t_h); m_ir = t_word[t_h]; m_halted = 1;
    end
  endtask

  task automatic clear_mem();
    for (int unsigned a = 0; a < 256; a++) mem[a] = '0;
  endtask

  initial begin
    int c0;
    logic [3:0] op;
    rst_n = 0; start = 0;
    clear_mem();
    tick(); tick();
    set_reset_exp();
    chk_on = 1;
    rst_n = 1;
    cmp("rst_pc", pc, 0);
    cmp("rst_retired", retired, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_halted", halted, 0);
    cmp("rst_imem_en", imem_en, 0);
    cmp("rst_opcode", dp_opcode, 0);
    cmp("rst_fields", {dp_dest, dp_src1, dp_src2, dp_imm}, 0);

    // ALU op then HALT
    mem[0] = 16'h1250; mem[1] = 16'hF000;
    c0 = opc_cnt;
    run_prog(30, 0);
    cmp("p1_opcode_cycles", opc_cnt - c0, 1);
    cmp("p1_opcode", l_op, 1);
    cmp("p1_dest", l_dest, 1);
    cmp("p1_src1", l_src1, 1);
    cmp("p1_src2", l_src2, 2);
    cmp("p1_halted", halted, 1);
    cmp("p1_pc", pc, 1);
    cmp("p1_retired", retired, 1);

    // JMP then HALT, restarted from HALTED with ignored start pulses
    clear_mem();
    mem[0] = 16'hD005; mem[5] = 16'hF000;
    c0 = opc_cnt;
    run_prog(30, 1);
    cmp("jmp_opcode_cycles", opc_cnt - c0, 0);
    cmp("jmp_pc", pc, 5);
    cmp("jmp_retired", retired, 1);
    cmp("jmp_halted", halted, 1);

    // Reset sampled in DECODE of instruction 0
    clear_mem();
    mem[0] = 16'h1250; mem[1] = 16'hF000;
    c0 = opc_cnt;
    run_prog(2, 0);
    cmp("rd_busy", busy, 0);
    cmp("rd_pc", pc, 0);
    cmp("rd_opcode_cycles", opc_cnt - c0, 0);

    // PC wrap FF -> 00
    clear_mem();
    mem[0] = 16'hD0FF; mem[8'hFF] = 16'h2000;
    wrap_seen = 0;
    run_prog(21, 1);
    cmp("wrap_trace", t_addr[2], 0);
    cmp("wrap_seen", wrap_seen, 1);

    // Random programs
    for (int r = 0; r < 40; r++) begin
      for (int unsigned a = 0; a < 256; a++) begin
        case ($urandom_range(0, 9))
          0:       op = 4'hF;
          1, 2:    op = 4'hD;
          3:       op = 4'h0;
          default: begin
            op = 4'($urandom_range(1, 14));
            if (op == 4'hD) op = 4'h7;
          end
        endcase
        mem[a] = {op, 12'($urandom)};
      end
      run_prog($urandom_range(2, 90), 1);
    end

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    chk_on = 0;
    clear_mem();
    mem[0] = 16'h1250; mem[1] = 16'hF000;
    step = 0;
    c0 = opc_cnt;
    tick(); start = 1;
    tick(); start = 0;
    for (int i = 0; i < 11; i++) tick();
    cmp("step_hold_busy", busy, 1);
    cmp("step_hold_en", imem_en, 0);
    cmp("step_hold_opcode", dp_opcode, 0);
    cmp("step_hold_cycles", opc_cnt - c0, 0);
    step = 1;
    tick(); step = 0;
    cmp("step_exec_opcode", dp_opcode, 1);
    tick(); tick(); tick();
    cmp("step_halted", halted, 1);
    cmp("step_retired", retired, 1);
    step = 1;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
